// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bundle: controller requests, program-memory req/ack handshake and fetch results.
// master = fetch unit, slave = controller and program memory.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  fetch;
  logic                  jump;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_rdata;
  logic [7:0]            instruction;
  logic                  LoadIR;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  busy;
  logic                  fetch_error;

  modport master (
    input  fetch, jump, jump_addr, mem_ack, mem_rdata,
    output mem_req, mem_addr, instruction, LoadIR, pc, busy, fetch_error
  );

  modport slave (
    output fetch, jump, jump_addr, mem_ack, mem_rdata,
    input  mem_req, mem_addr, instruction, LoadIR, pc, busy, fetch_error
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Owns the PC and fetches 8-bit words over req/ack; fetch->mem_req 1 cycle, ack->LoadIR 1 cycle.
// mem_req is held until acked or until the wait budget expires, which locks the unit in ERROR.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH     = 5,
  parameter int RESET_PC       = 0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t                r_state,     w_state;
  logic [ADDR_WIDTH-1:0] r_pc,        w_pc;
  logic                  r_mem_req,   w_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr;
  logic [7:0]            r_instr,     w_instr;
  logic                  r_load_ir,   w_load_ir;
  logic                  r_busy,      w_busy;
  logic                  r_err,       w_err;
  logic [CW-1:0]         r_cnt,       w_cnt;
  logic                  r_pend_vld,  w_pend_vld;
  logic [ADDR_WIDTH-1:0] r_pend_addr, w_pend_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= ADDR_WIDTH'(RESET_PC);
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_instr     <= '0;
      r_load_ir   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_mem_req   <= w_mem_req;
      r_mem_addr  <= w_mem_addr;
      r_instr     <= w_instr;
      r_load_ir   <= w_load_ir;
      r_busy      <= w_busy;
      r_err       <= w_err;
      r_cnt       <= w_cnt;
      r_pend_vld  <= w_pend_vld;
      r_pend_addr <= w_pend_addr;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_mem_req   = r_mem_req;
    w_mem_addr  = r_mem_addr;
    w_instr     = r_instr;
    w_load_ir   = 1'b0;
    w_busy      = r_busy;
    w_err       = r_err;
    w_cnt       = r_cnt;
    w_pend_vld  = r_pend_vld;
    w_pend_addr = r_pend_addr;

    case (r_state)
      S_IDLE: begin
        if (bus.jump) begin
          w_pc = bus.jump_addr;
        end else if (bus.fetch) begin
          w_mem_addr = r_pc;
          w_mem_req  = 1'b1;
          w_busy     = 1'b1;
          w_cnt      = '0;
          w_pend_vld = 1'b0;
          w_state    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.jump) begin
          w_pend_vld  = 1'b1;
          w_pend_addr = bus.jump_addr;
        end
        if (bus.mem_ack) begin
          w_instr    = bus.mem_rdata;
          w_load_ir  = 1'b1;
          w_mem_req  = 1'b0;
          w_busy     = 1'b0;
          // A jump arriving with the ack is the latest redirect, so it beats the pending one.
          w_pc       = w_pend_vld ? w_pend_addr : r_pc + ADDR_WIDTH'(1);
          w_pend_vld = 1'b0;
          w_state    = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_mem_req  = 1'b0;
          w_busy     = 1'b0;
          w_err      = 1'b1;
          w_pend_vld = 1'b0;
          w_state    = S_ERROR;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      S_ERROR: begin
        w_mem_req = 1'b0;
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instruction = r_instr;
  assign bus.LoadIR      = r_load_ir;
  assign bus.pc          = r_pc;
  assign bus.busy        = r_busy;
  assign bus.fetch_error = r_err;

endmodule
